shift_rotate_engine: RTL
========================

// Module: shift_rotate_engine
// PURPOSE
//  Parametrised multi-mode shift/rotate register: loads a WIDTH-bit word, then on
//  start runs a multi-cycle shift/rotate of a programmable amount, STEP bits/cycle.
//  Provides a start/busy/done handshake, abort, serial fill, and carry-out of the
//  last bit moved. Successor to the single-bit load/rotate register in the datapath.
// PARAMETERS
//  WIDTH  8  data word width (>=2)
//  STEP   1  max bit positions moved per cycle (1..WIDTH)
//  AMT_W  4  width of amount port; amount range 0..2^AMT_W-1
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  ld         in   1       load data_in into register (IDLE only)
//  data_in    in   WIDTH   parallel load value
//  start      in   1       begin operation (IDLE only)
//  mode       in   3       operation select, sampled with start
//  amount     in   AMT_W   total bit positions, sampled with start
//  ser_in     in   1       fill bit for serial modes, sampled every step
//  abort      in   1       terminate operation, keep partial result
//  busy       out  1       operation in progress
//  done       out  1       one-cycle pulse: operation completed
//  data_out   out  WIDTH   register contents
//  carry_out  out  1       last bit shifted/rotated out of the word
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, data_out=0, busy=0, done=0, carry_out=0.
//  Modes: 000 ROL, 001 ROR, 010 SHL zero-fill, 011 SHR zero-fill,
//   100 SAR (msb-fill), 101 SHL ser_in-fill, 110 SHR ser_in-fill, 111 reserved.
//  FSM IDLE/SHIFT. IDLE: ld=1 -> data_out<=data_in (ld beats start; start ignored);
//   else start=1 and mode!=111 -> latch mode, rem<=amount, SHIFT, busy=1.
//   start with mode=111 ignored (stays IDLE, no done).
//  SHIFT: each edge moves k=min(STEP,rem) positions, rem<=rem-k; 1-bit steps
//   applied k times within the cycle (serial fill uses same ser_in for all k bits).
//  carry_out <= last bit leaving the word on each step (rotate: bit that wrapped).
//  When rem reaches 0 on a step edge: -> IDLE, busy=0, done=1 for next cycle.
//  Latency: done high after edge start+max(1,ceil(amount/STEP)).
//  amount=0: one SHIFT cycle, data_out and carry_out unchanged, then done.
//  amount>=WIDTH: rotates wrap naturally; shifts saturate to fill pattern.
//  abort=1 in SHIFT: -> IDLE next edge, no step that edge, busy=0, no done,
//   data_out holds partial result. abort in IDLE: no effect.
//  ld/start while busy: ignored. done never coincides with busy=1.
//  Reset mid-operation: immediate return to reset values, done not issued.
// TESTING
//  T1 W=8,S=1: ld 0x7A; ROL amt 3 -> 0xF4,0xE9,0xD3 on 3 edges, carry=1, done 1 cyc.
//  T2 W=8,S=1: ld 0x9A; SAR amt 2 -> 0xCD,0xE6, carry=1; SHR amt 2 from 0x9A -> 0x26.
//  T3 W=8,S=3: ld 0xAA; ROR amt 8 -> steps 3,3,2, busy 3 cycles, final 0xAA.
//  T4 W=8,S=1: ld 0x00; mode 110 ser_in=1 amt 4 -> 0xF0; amt 0 -> unchanged, done.
//  T5 ld+start same edge -> load only; start mode 111 -> no busy/done; start in
//   SHIFT ignored; abort after 2 of 5 ROL steps from 0x81 -> 0x06, no done.
//  T6 rst low mid-SHIFT -> all outputs 0 immediately; new op after release is clean.

Source files
------------

// File: rtl/shift_rotate_engine.sv
// Multi-cycle shift/rotate register with start/busy/done handshake.
// Moves up to STEP bit positions per cycle until the programmed amount is consumed.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   ld        load data_in (IDLE only, has priority over start)
//   data_in   parallel load value
//   start     begin an operation (IDLE only)
//   mode      operation select, sampled with start
//   amount    total bit positions to move, sampled with start
//   ser_in    fill bit for the serial-fill modes, sampled every step
//   abort     end the operation, keeping the partial result
//   busy      operation in progress
//   done      one-cycle completion pulse
//   data_out  register contents
//   carry_out last bit moved out of the word
module shift_rotate_engine #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] data_in,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             ser_in,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic             carry_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        M_ROL  = 3'b000,
        M_ROR  = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_SAR  = 3'b100,
        M_SHLS = 3'b101,
        M_SHRS = 3'b110,
        M_RSVD = 3'b111
    } mode_t;

    state_t           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;

    // One-bit move; result is {bit that left the word, new word}.
    function automatic logic [WIDTH:0] step1(
        input logic [WIDTH-1:0] d,
        input logic [2:0]       m,
        input logic             s
    );
        logic [WIDTH:0] r;
        case (m)
            M_ROL:   r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            M_ROR:   r = {d[0], d[0], d[WIDTH-1:1]};
            M_SHL:   r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            M_SHR:   r = {d[0], 1'b0, d[WIDTH-1:1]};
            M_SAR:   r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            M_SHLS:  r = {d[WIDTH-1], d[WIDTH-2:0], s};
            M_SHRS:  r = {d[0], s, d[WIDTH-1:1]};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    always_comb begin
        logic [WIDTH:0] t;
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        data_d  = data_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        t       = '0;
        case (state_q)
            IDLE: begin
                if (ld) begin
                    data_d = data_in;
                end else if (start && mode != M_RSVD) begin
                    mode_d  = mode;
                    rem_d   = amount;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Apply min(STEP, rem) single-bit moves; carry tracks
                    // the last one and stays put when nothing moves.
                    for (int i = 0; i < STEP; i++) begin
                        if (i < int'(rem_q)) begin
                            t       = step1(data_d, mode_q, ser_in);
                            data_d  = t[WIDTH-1:0];
                            carry_d = t[WIDTH];
                        end
                    end
                    if (int'(rem_q) > STEP) begin
                        rem_d = rem_q - AMT_W'(STEP);
                    end else begin
                        rem_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            mode_q  <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = done_q;
    assign data_out  = data_q;
    assign carry_out = carry_q;

endmodule
